// File: rtl/tcm_boot_loader.sv
// Byte-stream boot loader: takes a length-prefixed little-endian image, writes it
// word by word into the TCM, then releases the core from reset.
module tcm_boot_loader #(
    parameter int unsigned        ADDR_W    = 17,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int unsigned WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_wr_q, mem_wr_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [31:0]       hdr_len;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        wd_d       = wd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        xfer       = s_valid && s_ready_q;
        hdr_len    = {s_data, len_q[23:0]};

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR;
                    len_d      = '0;
                    byte_idx_d = '0;
                    cnt_d      = '0;
                    addr_d     = BASE_ADDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    len_d[{byte_idx_q, 3'b000} +: 8] = s_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (hdr_len == 32'd0) begin
                            state_d = S_DONE;
                        end else if ({1'b0, hdr_len} > CAPACITY) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                            addr_d  = BASE_ADDR;
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = s_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    cnt_d  = cnt_q + (ADDR_W + 1)'(1);
                    addr_d = addr_q + ADDR_W'(1);
                    if (33'(cnt_q) + 33'd1 == {1'b0, len_q}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle watchdog: only runs while waiting on the byte stream
        if (state_q == S_HDR || state_q == S_DATA) begin
            if (xfer) begin
                wd_d = '0;
            end else begin
                wd_d = wd_q + WD_W'(1);
                if (wd_d == WD_W'(TIMEOUT)) begin
                    state_d = S_ERR;
                end
            end
        end else begin
            wd_d = '0;
        end

        s_ready_d  = (state_d == S_HDR) || (state_d == S_DATA);
        mem_wr_d   = (state_d == S_WRITE);
        busy_d     = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        core_rst_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_idx_q <= '0;
            wd_q       <= '0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            cnt_q      <= '0;
            s_ready_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            wd_q       <= wd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            s_ready_q  <= s_ready_d;
            mem_wr_q   <= mem_wr_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Self-checking bench for tcm_boot_loader: scoreboard of expected TCM writes
// plus per-scenario cycle-accurate checks on the control outputs.
module tb_tcm_boot_loader;

    localparam int unsigned AW = 17;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          mem_ack = 1'b0;
    logic          sel;

    logic          s_ready0, mem_wr0, core_rst0, busy0, done0, err0;
    logic [AW-1:0] mem_addr0;
    logic [31:0]   mem_wdata0;
    logic [AW:0]   word_cnt0;
    logic          s_ready1, mem_wr1, core_rst1, busy1, done1, err1;
    logic [AW-1:0] mem_addr1;
    logic [31:0]   mem_wdata1;
    logic [AW:0]   word_cnt1;

    logic          m_ready, m_wr, m_done, m_err, m_core_rst, m_busy;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [AW:0]   m_cnt;

    int            checks = 0;
    int            errors = 0;
    int            ack_delay = 0;
    bit            ack_tie = 1'b1;
    wr_t           exp_q[$];
    logic [7:0]    nom[$];
    logic [7:0]    img[$];

    tcm_boot_loader #(.ADDR_W(AW), .BASE_ADDR(17'h00000), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready0), .mem_wr(mem_wr0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_ack(mem_ack), .core_rst(core_rst0), .busy(busy0), .done(done0), .err(err0),
        .word_cnt(word_cnt0)
    );

    tcm_boot_loader #(.ADDR_W(AW), .BASE_ADDR(17'h1FFFF), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_ack(mem_ack), .core_rst(core_rst1), .busy(busy1), .done(done1), .err(err1),
        .word_cnt(word_cnt1)
    );

    assign m_ready    = sel ? s_ready1   : s_ready0;
    assign m_wr       = sel ? mem_wr1    : mem_wr0;
    assign m_done     = sel ? done1      : done0;
    assign m_err      = sel ? err1       : err0;
    assign m_core_rst = sel ? core_rst1  : core_rst0;
    assign m_busy     = sel ? busy1      : busy0;
    assign m_addr     = sel ? mem_addr1  : mem_addr0;
    assign m_wdata    = sel ? mem_wdata1 : mem_wdata0;
    assign m_cnt      = sel ? word_cnt1  : word_cnt0;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench did not terminate");
    end

    // TCM model: drives mem_ack, checks held write payloads, pops the scoreboard
    task automatic monitor();
        int            ack_wait = 0;
        logic          prev_wr = 1'b0;
        logic          prev_hs = 1'b0;
        logic          hs;
        logic [AW-1:0] prev_addr = '0;
        logic [31:0]   prev_data = '0;
        wr_t           e;
        forever begin
            @(negedge clk);
            if (m_wr && prev_wr && !prev_hs) begin
                checks++;
                if (m_addr !== prev_addr || m_wdata !== prev_data) begin
                    errors++;
                    $display("FAIL write_hold: addr %h data %h, required addr %h data %h",
                             m_addr, m_wdata, prev_addr, prev_data);
                end
            end
            if (ack_tie) begin
                mem_ack = 1'b1;
            end else if (m_wr && !mem_ack) begin
                if (ack_wait >= ack_delay) mem_ack = 1'b1;
                else ack_wait++;
            end else begin
                mem_ack  = 1'b0;
                ack_wait = 0;
            end
            hs = m_wr && mem_ack;
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, required no write", m_addr, m_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_addr !== e.addr || m_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write_data: addr %h data %h, required addr %h data %h",
                                 m_addr, m_wdata, e.addr, e.data);
                    end
                end
            end
            prev_wr   = m_wr;
            prev_hs   = hs;
            prev_addr = m_addr;
            prev_data = m_wdata;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n = 0;
        logic rdy;
        s_data  = b;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = m_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        s_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte %h not accepted in %0d cycles, required acceptance", b, n);
        end
    endtask

    task automatic send_bytes(input logic [7:0] im[$], input int from, input int to, input int gap_max);
        for (int i = from; i < to; i++) begin
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
            send_byte(im[i]);
        end
    endtask

    task automatic push_expected(input logic [7:0] im[$], input logic [AW-1:0] base);
        logic [31:0] len;
        wr_t         e;
        len = {im[3], im[2], im[1], im[0]};
        for (int w = 0; w < int'(len); w++) begin
            e.addr = base + AW'(w);
            e.data = {im[4*w+7], im[4*w+6], im[4*w+5], im[4*w+4]};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!m_done && !m_err && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (m_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b err=%b after %0d cycles, required done=1", m_done, m_err, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        checks++;
        if ({s_ready0, mem_wr0, core_rst0, busy0, done0, err0} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_flags: ready/wr/core_rst/busy/done/err=%b, required 001000",
                     {s_ready0, mem_wr0, core_rst0, busy0, done0, err0});
        end
        checks++;
        if (mem_addr0 !== 17'h00000 || mem_wdata0 !== 32'h0 || word_cnt0 !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h cnt %0d, required 0 0 0", mem_addr0, mem_wdata0, word_cnt0);
        end
        checks++;
        if (mem_addr1 !== 17'h1FFFF) begin
            errors++;
            $display("FAIL reset_base: addr %h, required 1ffff", mem_addr1);
        end
    endtask

    task automatic test_nominal();
        sel = 1'b0;
        ack_tie = 1'b1;
        push_expected(nom, 17'h0);
        pulse_start();
        checks++;
        if (m_ready !== 1'b1 || m_busy !== 1'b1 || m_core_rst !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: ready=%b busy=%b core_rst=%b, required 1 1 1", m_ready, m_busy, m_core_rst);
        end
        send_bytes(nom, 0, 8, 0);
        checks++;
        if (m_wr !== 1'b1 || m_ready !== 1'b0) begin
            errors++;
            $display("FAIL word0_write: wr=%b ready=%b, required 1 0", m_wr, m_ready);
        end
        idle(1);
        checks++;
        if (m_wr !== 1'b0 || m_cnt !== 18'd1 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL word0_ack: wr=%b cnt=%0d ready=%b, required 0 1 1", m_wr, m_cnt, m_ready);
        end
        send_bytes(nom, 8, 12, 0);
        checks++;
        if (m_wr !== 1'b1 || m_core_rst !== 1'b1) begin
            errors++;
            $display("FAIL word1_write: wr=%b core_rst=%b, required 1 1", m_wr, m_core_rst);
        end
        idle(1);
        checks++;
        if (m_done !== 1'b1 || m_core_rst !== 1'b0 || m_cnt !== 18'd2 || m_err !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done: done=%b core_rst=%b cnt=%0d err=%b busy=%b, required 1 0 2 0 0",
                     m_done, m_core_rst, m_cnt, m_err, m_busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL nominal_writes: %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        ack_tie = 1'b0;
        ack_delay = 3;
        push_expected(nom, 17'h0);
        pulse_start();
        send_bytes(nom, 0, 12, 6);
        wait_done(200);
        checks++;
        if (m_cnt !== 18'd2 || m_core_rst !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_end: cnt=%0d core_rst=%b outstanding=%0d, required 2 0 0",
                     m_cnt, m_core_rst, exp_q.size());
        end
        ack_tie = 1'b1;
    endtask

    task automatic test_zero_len();
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        send_bytes(img, 0, 4, 0);
        checks++;
        if (m_done !== 1'b1 || m_core_rst !== 1'b0 || m_wr !== 1'b0 || m_cnt !== '0) begin
            errors++;
            $display("FAIL zero_len: done=%b core_rst=%b wr=%b cnt=%0d, required 1 0 0 0",
                     m_done, m_core_rst, m_wr, m_cnt);
        end
    endtask

    task automatic test_oversize();
        img = '{8'h01, 8'h00, 8'h02, 8'h00};
        pulse_start();
        send_bytes(img, 0, 4, 0);
        checks++;
        if (m_err !== 1'b1 || m_core_rst !== 1'b1 || m_wr !== 1'b0 || m_busy !== 1'b0 || m_cnt !== '0) begin
            errors++;
            $display("FAIL oversize: err=%b core_rst=%b wr=%b busy=%b cnt=%0d, required 1 1 0 0 0",
                     m_err, m_core_rst, m_wr, m_busy, m_cnt);
        end
    endtask

    task automatic test_restart();
        push_expected(nom, 17'h0);
        pulse_start();
        checks++;
        if (m_err !== 1'b0 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: err=%b ready=%b, required 0 1", m_err, m_ready);
        end
        send_bytes(nom, 0, 12, 2);
        wait_done(50);
        checks++;
        if (m_cnt !== 18'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_end: cnt=%0d outstanding=%0d, required 2 0", m_cnt, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        sel = 1'b1;
        push_expected(nom, 17'h1FFFF);
        pulse_start();
        send_bytes(nom, 0, 12, 0);
        wait_done(50);
        checks++;
        if (m_cnt !== 18'd2 || m_addr !== 17'h00001 || m_err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_end: cnt=%0d addr=%h err=%b outstanding=%0d, required 2 00001 0 0",
                     m_cnt, m_addr, m_err, exp_q.size());
        end
        sel = 1'b0;
    endtask

    task automatic test_timeout();
        pulse_start();
        send_bytes(nom, 0, 6, 0);
        idle(15);
        checks++;
        if (m_err !== 1'b0 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b busy=%b after 15 idle cycles, required 0 1", m_err, m_busy);
        end
        idle(1);
        checks++;
        if (m_err !== 1'b1 || m_cnt !== '0 || m_core_rst !== 1'b1 || m_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b cnt=%0d core_rst=%b ready=%b, required 1 0 1 0",
                     m_err, m_cnt, m_core_rst, m_ready);
        end
    endtask

    task automatic test_start_mid_data();
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        push_expected(img, 17'h0);
        pulse_start();
        send_bytes(img, 0, 6, 0);
        pulse_start();
        checks++;
        if (m_busy !== 1'b1 || m_ready !== 1'b1 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: busy=%b ready=%b done=%b, required 1 1 0", m_busy, m_ready, m_done);
        end
        send_bytes(img, 6, 8, 0);
        idle(1);
        checks++;
        if (m_done !== 1'b1 || m_cnt !== 18'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_start_end: done=%b cnt=%0d outstanding=%0d, required 1 1 0",
                     m_done, m_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        ack_tie = 1'b0;
        ack_delay = 10;
        push_expected(img, 17'h0);
        pulse_start();
        send_bytes(img, 0, 8, 0);
        checks++;
        if (m_wr !== 1'b1 || m_wdata !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL pre_reset_write: wr=%b data=%h, required 1 ddccbbaa", m_wr, m_wdata);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready0, mem_wr0, core_rst0, busy0, done0, err0} !== 6'b001000 ||
            mem_addr0 !== 17'h0 || mem_wdata0 !== 32'h0 || word_cnt0 !== '0) begin
            errors++;
            $display("FAIL async_reset: flags=%b addr=%h data=%h cnt=%0d, required 001000 0 0 0",
                     {s_ready0, mem_wr0, core_rst0, busy0, done0, err0}, mem_addr0, mem_wdata0, word_cnt0);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        ack_tie = 1'b1;
        push_expected(nom, 17'h0);
        pulse_start();
        send_bytes(nom, 0, 12, 0);
        wait_done(50);
        checks++;
        if (m_cnt !== 18'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_load: cnt=%0d outstanding=%0d, required 2 0", m_cnt, exp_q.size());
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        sel     = 1'b0;
        nom = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        fork
            monitor();
        join_none
        test_reset();
        test_nominal();
        test_backpressure();
        test_zero_len();
        test_oversize();
        test_restart();
        test_wrap();
        test_timeout();
        test_start_mid_data();
        test_reset_mid_write();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
